// File: rtl/spi_byte_slave.sv
// SPI mode-0 slave front end: oversamples the SPI pins on sys_clk, delivers
// received bytes with a data_rdy strobe and shifts shadowed tx bytes out on miso.
module spi_byte_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic [7:0] rx_data,
  output logic       data_rdy,
  input  logic [7:0] tx_data,
  input  logic       data_latch,
  output logic       tx_underrun,
  output logic       frame_active
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_r;
  logic [SYNC_STAGES-1:0] cs_sync_r;
  logic [SYNC_STAGES-1:0] mosi_sync_r;
  logic                   sclk_s;
  logic                   cs_s;
  logic                   mosi_s;
  logic                   sclk_d_r;
  logic                   cs_d_r;
  logic                   sclk_rise_r;
  logic                   sclk_fall_r;
  logic                   cs_fall_r;
  logic                   cs_rise_r;

  state_t                 state_r;
  logic [2:0]             bit_cnt_r;
  logic                   shifted_r;
  logic [6:0]             rx_shift_r;
  logic [7:0]             tx_shift_r;
  logic [7:0]             shadow_r;
  logic                   shadow_vld_r;

  logic                   load_s;
  logic [7:0]             load_val_s;
  logic                   underrun_s;

  assign sclk_s       = sclk_sync_r[SYNC_STAGES-1];
  assign cs_s         = cs_sync_r[SYNC_STAGES-1];
  assign mosi_s       = mosi_sync_r[SYNC_STAGES-1];
  assign miso         = tx_shift_r[7];
  assign frame_active = (state_r == SHIFT);

  // Pin synchronizers, history flops and registered single-cycle edge detects.
  // The cs_n chain resets low so a select held low across reset never looks like a fresh fall.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_r <= '0;
      cs_sync_r   <= '0;
      mosi_sync_r <= '0;
      sclk_d_r    <= 1'b0;
      cs_d_r      <= 1'b0;
      sclk_rise_r <= 1'b0;
      sclk_fall_r <= 1'b0;
      cs_fall_r   <= 1'b0;
      cs_rise_r   <= 1'b0;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], sclk};
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], cs_n};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], mosi};
      sclk_d_r    <= sclk_s;
      cs_d_r      <= cs_s;
      sclk_rise_r <= sclk_s & ~sclk_d_r;
      sclk_fall_r <= ~sclk_s & sclk_d_r;
      cs_fall_r   <= ~cs_s & cs_d_r;
      cs_rise_r   <= cs_s & ~cs_d_r;
    end
  end

  // Byte-load decision and the value such a load places in tx_shift.
  always_comb begin
    load_s     = 1'b0;
    load_val_s = 8'h00;
    underrun_s = 1'b0;
    if (state_r == IDLE) begin
      load_s = cs_fall_r & ~sclk_d_r;
    end else begin
      load_s = ~cs_rise_r & sclk_fall_r & shifted_r & (bit_cnt_r == 3'd0);
    end
    if (data_latch) begin
      load_val_s = tx_data;
    end else if (shadow_vld_r) begin
      load_val_s = shadow_r;
    end else begin
      load_val_s = 8'h00;
    end
    underrun_s = load_s & ~data_latch & ~shadow_vld_r;
  end

  // Tx shadow register: written by the core, drained by byte loads.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_r     <= 8'h00;
      shadow_vld_r <= 1'b0;
    end else if (load_s) begin
      shadow_vld_r <= 1'b0;
    end else if (data_latch) begin
      shadow_r     <= tx_data;
      shadow_vld_r <= 1'b1;
    end
  end

  // Frame state machine with rx deserializer and tx serializer.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      bit_cnt_r   <= 3'd0;
      shifted_r   <= 1'b0;
      rx_shift_r  <= 7'h00;
      rx_data     <= 8'h00;
      data_rdy    <= 1'b0;
      tx_shift_r  <= 8'h00;
      tx_underrun <= 1'b0;
    end else begin
      data_rdy    <= 1'b0;
      tx_underrun <= underrun_s;
      case (state_r)
        IDLE: begin
          bit_cnt_r <= 3'd0;
          shifted_r <= 1'b0;
          if (load_s) begin
            state_r    <= SHIFT;
            tx_shift_r <= load_val_s;
          end else begin
            tx_shift_r <= 8'h00;
          end
        end
        SHIFT: begin
          if (cs_rise_r) begin
            // Abort: any partial byte is dropped, rx_data keeps its last value.
            state_r    <= IDLE;
            bit_cnt_r  <= 3'd0;
            shifted_r  <= 1'b0;
            tx_shift_r <= 8'h00;
          end else begin
            if (sclk_rise_r) begin
              rx_shift_r <= {rx_shift_r[5:0], mosi_s};
              bit_cnt_r  <= bit_cnt_r + 3'd1;
              shifted_r  <= 1'b1;
              if (bit_cnt_r == 3'd7) begin
                rx_data  <= {rx_shift_r, mosi_s};
                data_rdy <= 1'b1;
              end
            end
            if (load_s) begin
              tx_shift_r <= load_val_s;
            end else if (sclk_fall_r) begin
              tx_shift_r <= {tx_shift_r[6:0], 1'b0};
            end
          end
        end
        default: begin
          state_r    <= IDLE;
          bit_cnt_r  <= 3'd0;
          shifted_r  <= 1'b0;
          tx_shift_r <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_byte_slave.sv
// Directed self-checking bench for spi_byte_slave: a bit-banged SPI master at
// sys_clk/10 with hand-computed expected bytes and strobe counts.
module tb_spi_byte_slave;

  logic       sys_clk = 1'b0;
  logic       rst_n;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  logic       miso;
  logic [7:0] rx_data;
  logic       data_rdy;
  logic [7:0] tx_data;
  logic       data_latch;
  logic       tx_underrun;
  logic       frame_active;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         rdy_cnt  = 0;
  int         urun_cnt = 0;
  int         rdy_long = 0;
  logic       rdy_prev = 1'b0;
  logic [7:0] rx_log [0:63];

  spi_byte_slave #(.SYNC_STAGES(2)) dut (
    .sys_clk      (sys_clk),
    .rst_n        (rst_n),
    .sclk         (sclk),
    .cs_n         (cs_n),
    .mosi         (mosi),
    .miso         (miso),
    .rx_data      (rx_data),
    .data_rdy     (data_rdy),
    .tx_data      (tx_data),
    .data_latch   (data_latch),
    .tx_underrun  (tx_underrun),
    .frame_active (frame_active)
  );

  always #5 sys_clk = ~sys_clk;

  // Strobe monitor: counts pulses, logs received bytes, flags over-long data_rdy.
  always @(negedge sys_clk) begin
    if (data_rdy) begin
      rx_log[rdy_cnt[5:0]] <= rx_data;
      rdy_cnt <= rdy_cnt + 1;
      if (rdy_prev) rdy_long <= rdy_long + 1;
    end
    if (tx_underrun) urun_cnt <= urun_cnt + 1;
    rdy_prev <= data_rdy;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic latch_byte(input logic [7:0] v);
    tx_data    = v;
    data_latch = 1'b1;
    wait_cyc(1);
    data_latch = 1'b0;
  endtask

  task automatic start_frame();
    cs_n = 1'b0;
  endtask

  // mode 1: latch lv during the high phase of the final bit of this call;
  // mode 2: latch lv in the cycle of the byte-boundary load after the final fall.
  task automatic xfer(input logic [7:0] mo, input int nbits, input bit last,
                      input int mode, input logic [7:0] lv, output logic [7:0] mi);
    mi = 8'h00;
    for (int k = 0; k < nbits; k++) begin
      mosi = mo[7-k];
      wait_cyc(5);
      mi[7-k] = miso;
      sclk = 1'b1;
      wait_cyc(5);
      if (mode == 1 && k == nbits - 1) latch_byte(lv);
      sclk = 1'b0;
      if (last && k == nbits - 1) cs_n = 1'b1;
    end
    if (mode == 2) begin
      wait_cyc(3);
      latch_byte(lv);
    end
    if (last) wait_cyc(10);
  endtask

  task automatic test_reset();
    #12;
    n_checks++; if (miso !== 1'b0) begin n_fail++; $display("FAIL reset_miso: got %b expected 0", miso); end
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
    n_checks++; if (data_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_data_rdy: got %b expected 0", data_rdy); end
    n_checks++; if (tx_underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun: got %b expected 0", tx_underrun); end
    n_checks++; if (frame_active !== 1'b0) begin n_fail++; $display("FAIL reset_frame_active: got %b expected 0", frame_active); end
    #3 rst_n = 1'b1;
    wait_cyc(5);
  endtask

  task automatic test_single_byte();
    logic [7:0] mi;
    int r0, u0;
    r0 = rdy_cnt; u0 = urun_cnt;
    start_frame();
    xfer(8'hA5, 8, 1'b1, 0, 8'h00, mi);
    n_checks++; if (rdy_cnt - r0 !== 1) begin n_fail++; $display("FAIL single_rdy_count: got %0d expected 1", rdy_cnt - r0); end
    n_checks++; if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL single_rx_data: got %h expected a5", rx_data); end
    n_checks++; if (mi !== 8'h00) begin n_fail++; $display("FAIL single_miso: got %h expected 00", mi); end
    n_checks++; if (urun_cnt - u0 !== 1) begin n_fail++; $display("FAIL single_underrun: got %0d expected 1", urun_cnt - u0); end
    n_checks++; if (frame_active !== 1'b0) begin n_fail++; $display("FAIL single_frame_end: got %b expected 0", frame_active); end
  endtask

  task automatic test_full_duplex();
    logic [7:0] m1, m2, m3;
    int r0, u0;
    r0 = rdy_cnt; u0 = urun_cnt;
    latch_byte(8'h3C);
    start_frame();
    xfer(8'h01, 8, 1'b0, 1, 8'h81, m1);
    xfer(8'h02, 8, 1'b0, 1, 8'hFF, m2);
    xfer(8'h03, 8, 1'b1, 0, 8'h00, m3);
    n_checks++; if (m1 !== 8'h3C) begin n_fail++; $display("FAIL duplex_miso0: got %h expected 3c", m1); end
    n_checks++; if (m2 !== 8'h81) begin n_fail++; $display("FAIL duplex_miso1: got %h expected 81", m2); end
    n_checks++; if (m3 !== 8'hFF) begin n_fail++; $display("FAIL duplex_miso2: got %h expected ff", m3); end
    n_checks++; if (rdy_cnt - r0 !== 3) begin n_fail++; $display("FAIL duplex_rdy_count: got %0d expected 3", rdy_cnt - r0); end
    n_checks++; if (rx_log[r0] !== 8'h01) begin n_fail++; $display("FAIL duplex_rx0: got %h expected 01", rx_log[r0]); end
    n_checks++; if (rx_log[r0+1] !== 8'h02) begin n_fail++; $display("FAIL duplex_rx1: got %h expected 02", rx_log[r0+1]); end
    n_checks++; if (rx_log[r0+2] !== 8'h03) begin n_fail++; $display("FAIL duplex_rx2: got %h expected 03", rx_log[r0+2]); end
    n_checks++; if (urun_cnt - u0 !== 0) begin n_fail++; $display("FAIL duplex_underrun: got %0d expected 0", urun_cnt - u0); end
    n_checks++; if (rdy_long !== 0) begin n_fail++; $display("FAIL rdy_width: got %0d long pulses expected 0", rdy_long); end
  endtask

  task automatic test_underrun();
    logic [7:0] m1, m2;
    int u0;
    u0 = urun_cnt;
    latch_byte(8'h55);
    start_frame();
    xfer(8'hC3, 8, 1'b0, 0, 8'h00, m1);
    xfer(8'h3C, 8, 1'b1, 0, 8'h00, m2);
    n_checks++; if (m1 !== 8'h55) begin n_fail++; $display("FAIL underrun_miso0: got %h expected 55", m1); end
    n_checks++; if (m2 !== 8'h00) begin n_fail++; $display("FAIL underrun_miso1: got %h expected 00", m2); end
    n_checks++; if (urun_cnt - u0 !== 1) begin n_fail++; $display("FAIL underrun_count: got %0d expected 1", urun_cnt - u0); end
    n_checks++; if (rx_data !== 8'h3C) begin n_fail++; $display("FAIL underrun_rx: got %h expected 3c", rx_data); end
  endtask

  task automatic test_abort();
    logic [7:0] mi;
    int r0, u0;
    r0 = rdy_cnt;
    start_frame();
    xfer(8'h12, 8, 1'b0, 0, 8'h00, mi);
    xfer(8'hF0, 5, 1'b1, 1, 8'h6E, mi);
    n_checks++; if (rdy_cnt - r0 !== 1) begin n_fail++; $display("FAIL abort_rdy_count: got %0d expected 1", rdy_cnt - r0); end
    n_checks++; if (rx_data !== 8'h12) begin n_fail++; $display("FAIL abort_rx_kept: got %h expected 12", rx_data); end
    r0 = rdy_cnt; u0 = urun_cnt;
    start_frame();
    xfer(8'h34, 8, 1'b1, 0, 8'h00, mi);
    n_checks++; if (rx_data !== 8'h34) begin n_fail++; $display("FAIL abort_next_rx: got %h expected 34", rx_data); end
    n_checks++; if (rdy_cnt - r0 !== 1) begin n_fail++; $display("FAIL abort_next_rdy: got %0d expected 1", rdy_cnt - r0); end
    n_checks++; if (mi !== 8'h6E) begin n_fail++; $display("FAIL abort_shadow_kept: got %h expected 6e", mi); end
    n_checks++; if (urun_cnt - u0 !== 0) begin n_fail++; $display("FAIL abort_next_underrun: got %0d expected 0", urun_cnt - u0); end
  endtask

  task automatic test_bypass();
    logic [7:0] m1, m2;
    int u0;
    u0 = urun_cnt;
    latch_byte(8'h44);
    start_frame();
    xfer(8'h0F, 8, 1'b0, 2, 8'h99, m1);
    xfer(8'hF0, 8, 1'b1, 0, 8'h00, m2);
    n_checks++; if (m1 !== 8'h44) begin n_fail++; $display("FAIL bypass_miso0: got %h expected 44", m1); end
    n_checks++; if (m2 !== 8'h99) begin n_fail++; $display("FAIL bypass_miso1: got %h expected 99", m2); end
    n_checks++; if (urun_cnt - u0 !== 0) begin n_fail++; $display("FAIL bypass_underrun: got %0d expected 0", urun_cnt - u0); end
  endtask

  task automatic test_async_reset();
    logic [7:0] mi;
    int r0;
    latch_byte(8'hFF);
    start_frame();
    xfer(8'hC0, 3, 1'b0, 0, 8'h00, mi);
    mosi = 1'b1;
    sclk = 1'b1;
    wait_cyc(2);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (miso !== 1'b0) begin n_fail++; $display("FAIL areset_miso: got %b expected 0", miso); end
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL areset_rx_data: got %h expected 00", rx_data); end
    n_checks++; if (frame_active !== 1'b0) begin n_fail++; $display("FAIL areset_frame_active: got %b expected 0", frame_active); end
    n_checks++; if (data_rdy !== 1'b0) begin n_fail++; $display("FAIL areset_data_rdy: got %b expected 0", data_rdy); end
    n_checks++; if (tx_underrun !== 1'b0) begin n_fail++; $display("FAIL areset_underrun: got %b expected 0", tx_underrun); end
    wait_cyc(3);
    rst_n = 1'b1;
    r0 = rdy_cnt;
    wait_cyc(3);
    sclk = 1'b0;
    wait_cyc(5);
    xfer(8'hAA, 4, 1'b1, 0, 8'h00, mi);
    n_checks++; if (rdy_cnt - r0 !== 0) begin n_fail++; $display("FAIL areset_no_resume: got %0d expected 0", rdy_cnt - r0); end
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL areset_rx_hold: got %h expected 00", rx_data); end
    start_frame();
    xfer(8'h6B, 8, 1'b1, 0, 8'h00, mi);
    n_checks++; if (rdy_cnt - r0 !== 1) begin n_fail++; $display("FAIL areset_new_rdy: got %0d expected 1", rdy_cnt - r0); end
    n_checks++; if (rx_data !== 8'h6B) begin n_fail++; $display("FAIL areset_new_rx: got %h expected 6b", rx_data); end
  endtask

  initial begin
    rst_n      = 1'b0;
    sclk       = 1'b0;
    cs_n       = 1'b1;
    mosi       = 1'b0;
    tx_data    = 8'h00;
    data_latch = 1'b0;
    test_reset();
    test_single_byte();
    test_full_duplex();
    test_underrun();
    test_abort();
    test_bypass();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
